// File: rtl/dot_product_pipe.sv
// Pipelined N-tap pixel x weight dot product with valid/ready flow control.
// Stages: input capture, products, registered adder tree, round/clamp output.
module dot_product_pipe #(
    parameter int TAPS      = 4,
    parameter int PIX_W     = 8,
    parameter int WGT_W     = 9,
    parameter int FRAC_BITS = 7,
    parameter int ACC_W     = PIX_W + WGT_W + 1 + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAPS*PIX_W-1:0]   pix_in,
    input  logic [TAPS*WGT_W-1:0]   wgt_in,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [PIX_W-1:0]        pix_out,
    output logic                    out_last,
    output logic [15:0]             sat_cnt
);

    localparam int LEVELS = $clog2(TAPS);
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int RND    = (FRAC_BITS > 0) ? 2 ** (FRAC_BITS - 1) : 0;
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'(2 ** PIX_W - 1);

    logic stall;

    logic [TAPS*PIX_W-1:0]    pix_q;
    logic [TAPS*WGT_W-1:0]    wgt_q;
    logic                     s_valid_q, s_last_q;

    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic                     p_valid_q, p_last_q;
    logic signed [ACC_W-1:0]  ext [TAPS];

    logic signed [ACC_W-1:0]  tree_acc;
    logic                     tree_valid, tree_last;

    logic signed [ACC_W:0]    rnd_sum, r_d;
    logic [PIX_W-1:0]         pix_d;
    logic                     clamp_d;

    logic                     out_valid_q, out_last_q, clamp_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [PIX_W-1:0]         pix_out_q;
    logic [15:0]              sat_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !rst && !stall;

    always_comb begin
        for (int unsigned i = 0; i < TAPS; i++) begin
            prod_d[i] = PROD_W'($signed({1'b0, pix_q[i*PIX_W +: PIX_W]}))
                      * PROD_W'($signed(wgt_q[i*WGT_W +: WGT_W]));
            ext[i]    = ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
        end else if (!stall) begin
            s_valid_q <= in_valid;
            s_last_q  <= in_last;
            p_valid_q <= s_valid_q;
            p_last_q  <= s_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            pix_q  <= pix_in;
            wgt_q  <= wgt_in;
            prod_q <= prod_d;
        end
    end

    // Each tree level halves the operand count; level l reads level l-1.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = TAPS >> (l + 1);
        logic signed [ACC_W-1:0] src [2*N];
        logic signed [ACC_W-1:0] sum_q [N];
        logic                    src_valid, src_last;
        logic                    sv_q, sl_q;

        if (l == 0) begin : g_src0
            assign src       = ext;
            assign src_valid = p_valid_q;
            assign src_last  = p_last_q;
        end else begin : g_srcn
            assign src       = g_lvl[l-1].sum_q;
            assign src_valid = g_lvl[l-1].sv_q;
            assign src_last  = g_lvl[l-1].sl_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sv_q <= 1'b0;
                sl_q <= 1'b0;
            end else if (!stall) begin
                sv_q <= src_valid;
                sl_q <= src_last;
                for (int unsigned j = 0; j < N; j++) begin
                    sum_q[j] <= src[2*j] + src[2*j+1];
                end
            end
        end
    end

    if (LEVELS == 0) begin : g_notree
        assign tree_acc   = ext[0];
        assign tree_valid = p_valid_q;
        assign tree_last  = p_last_q;
    end else begin : g_tree
        assign tree_acc   = g_lvl[LEVELS-1].sum_q[0];
        assign tree_valid = g_lvl[LEVELS-1].sv_q;
        assign tree_last  = g_lvl[LEVELS-1].sl_q;
    end

    // One guard bit so the rounding offset cannot wrap the accumulator.
    always_comb begin
        rnd_sum = (ACC_W + 1)'(tree_acc) + (ACC_W + 1)'(RND);
        r_d     = rnd_sum >>> FRAC_BITS;
        pix_d   = r_d[PIX_W-1:0];
        clamp_d = 1'b0;
        if (r_d[ACC_W]) begin
            pix_d   = '0;
            clamp_d = 1'b1;
        end else if (r_d > PIX_MAX) begin
            pix_d   = '1;
            clamp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            clamp_q     <= 1'b0;
            acc_q       <= '0;
            pix_out_q   <= '0;
            sat_q       <= '0;
        end else begin
            if (out_valid_q && out_ready && clamp_q && sat_q != '1) begin
                sat_q <= sat_q + 16'd1;
            end
            if (!stall) begin
                out_valid_q <= tree_valid;
                out_last_q  <= tree_last;
                clamp_q     <= clamp_d;
                acc_q       <= tree_acc;
                pix_out_q   <= pix_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign acc_out   = acc_q;
    assign pix_out   = pix_out_q;
    assign sat_cnt   = sat_q;

endmodule
